// File: rtl/data_memory_sync.sv
// Byte-addressable synchronous data memory with a power-up clear sequence,
// sub-word loads/stores, one-cycle registered loads and error pulses.
module data_memory_sync #(
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  memWrite,
    input  logic                  memRead,
    input  logic [1:0]            size,
    input  logic                  unsignedLoad,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic                  readValid,
    output logic                  ready,
    output logic                  misaligned,
    output logic                  outOfRange
);

    localparam int AW = $clog2(DEPTH);
    typedef logic [ADDR_WIDTH:0] ext_addr_t;
    localparam ext_addr_t LIMIT = ext_addr_t'(4 * DEPTH);

    typedef enum logic {S_INIT, S_IDLE} state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [AW-1:0]   r_clear_idx;
    logic [31:0]     r_mem [DEPTH];
    logic [31:0]     r_readdata;
    logic            r_read_valid;
    logic            r_misaligned;
    logic            r_oor;

    logic            w_accept;
    logic            w_misaligned;
    logic            w_oor;
    logic            w_ok;
    logic [AW-1:0]   w_word_idx;
    logic [1:0]      w_lane;
    logic [3:0]      w_be;
    logic [31:0]     w_wdata;
    logic [31:0]     w_rword;
    logic [7:0]      w_rbyte;
    logic [15:0]     w_rhalf;
    logic [31:0]     w_load;

    assign w_word_idx   = address[AW+1:2];
    assign w_lane       = address[1:0];
    assign w_accept     = (r_state == S_IDLE) && (memWrite || memRead);
    assign w_misaligned = (size == 2'b11)
                       || ((size == 2'b01) && address[0])
                       || ((size == 2'b10) && (address[1:0] != 2'b00));
    assign w_oor        = {1'b0, address} >= LIMIT;
    assign w_ok         = w_accept && !w_misaligned && !w_oor;

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_INIT;
            r_clear_idx <= '0;
        end else begin
            r_state     <= w_next_state;
            r_clear_idx <= (r_state == S_INIT) ? r_clear_idx + 1'b1 : '0;
        end
    end

    // FSM: next state
    always_comb begin
        w_next_state = r_state;
        if ((r_state == S_INIT) && (r_clear_idx == AW'(DEPTH - 1)))
            w_next_state = S_IDLE;
    end

    // FSM: outputs
    always_comb begin
        ready = (r_state == S_IDLE);
    end

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        w_be    = '0;
        w_wdata = writedata;
        case (size)
            2'b00: begin
                w_be    = 4'b0001 << w_lane;
                w_wdata = {4{writedata[7:0]}};
            end
            2'b01: begin
                w_be    = address[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{writedata[15:0]}};
            end
            2'b10:   w_be = 4'b1111;
            default: w_be = '0;
        endcase
    end

    always_comb begin
        w_rword = r_mem[w_word_idx];
        w_rbyte = w_rword[{w_lane, 3'b000} +: 8];
        w_rhalf = w_rword[{address[1], 4'b0000} +: 16];
        case (size)
            2'b00:   w_load = unsignedLoad ? {24'b0, w_rbyte} : {{24{w_rbyte[7]}}, w_rbyte};
            2'b01:   w_load = unsignedLoad ? {16'b0, w_rhalf} : {{16{w_rhalf[15]}}, w_rhalf};
            default: w_load = w_rword;
        endcase
    end

    // Storage carries no reset; the INIT sweep does the clearing.
    always_ff @(posedge clk) begin
        if (r_state == S_INIT) begin
            r_mem[r_clear_idx] <= '0;
        end else if (w_ok && memWrite) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (w_be[i])
                    r_mem[w_word_idx][8*i +: 8] <= w_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_readdata   <= '0;
            r_read_valid <= 1'b0;
            r_misaligned <= 1'b0;
            r_oor        <= 1'b0;
        end else begin
            r_read_valid <= w_ok && memRead && !memWrite;
            r_misaligned <= w_accept && w_misaligned;
            r_oor        <= w_accept && w_oor;
            if (w_ok && memRead && !memWrite)
                r_readdata <= w_load;
        end
    end

    assign readdata   = r_readdata;
    assign readValid  = r_read_valid;
    assign misaligned = r_misaligned;
    assign outOfRange = r_oor;

endmodule

// File: doc/data_memory_sync.md
DATA_MEMORY_SYNC -- requirements
Module: data_memory_sync

Interface
REQ-001 Parameter DEPTH, 256, number of 32-bit words stored; power of two, minimum 4.
REQ-002 Parameter ADDR_WIDTH, 32, width of the byte address input.
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 Port memWrite  input  1  store request, sampled at the rising edge.
REQ-006 Port memRead  input  1  load request, sampled at the rising edge.
REQ-007 Port size  input  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
REQ-008 Port unsignedLoad  input  1  1 = zero-extend sub-word loads; 0 = sign-extend.
REQ-009 Port address  input  ADDR_WIDTH  byte address.
REQ-010 Port writedata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 Port readdata  output  32  load result, registered.
REQ-012 Port readValid  output  1  one-cycle pulse: readdata holds a new load result.
REQ-013 Port ready  output  1  high when requests are accepted.
REQ-014 Port misaligned  output  1  one-cycle pulse: previous request was misaligned or used size 11.
REQ-015 Port outOfRange  output  1  one-cycle pulse: previous request had address >= 4*DEPTH.

Function
REQ-016 The block SHALL have two states: INIT (clearing memory) and IDLE (servicing requests).
REQ-017 In INIT, the block SHALL write zero to word clearIdx each cycle, increment clearIdx, and enter IDLE on the cycle after clearing word DEPTH-1, for exactly DEPTH clearing cycles.
REQ-018 ready SHALL be 0 in INIT and 1 in IDLE; requests during INIT SHALL be ignored with no flags.
REQ-019 Word index SHALL be address[log2(DEPTH)+1:2]; byte lane SHALL be address[1:0].
REQ-020 A request is accepted in IDLE when memWrite or memRead is 1 at a rising edge.
REQ-021 memWrite and memRead both 1: write SHALL be performed, read dropped, readValid stays 0.
REQ-022 Misaligned means: half with address[0]=1; word with address[1:0]!=00; any access with size 11.
REQ-023 Misaligned or out-of-range requests SHALL leave memory and readdata unchanged, produce no readValid, and pulse the matching flag(s) the cycle after acceptance; both flags may pulse together.
REQ-024 Byte store SHALL write writedata[7:0] to lane address[1:0]; half store SHALL write writedata[15:0] to lanes {address[1],0}..+1; word store SHALL write all 4 lanes; other lanes SHALL be unchanged.
REQ-025 Load latency SHALL be 1 cycle: readdata updates and readValid pulses on the edge following acceptance.
REQ-026 Sub-word loads SHALL extract the addressed lane(s) to bits [7:0]/[15:0] and extend per unsignedLoad; word loads ignore unsignedLoad.
REQ-027 readdata SHALL hold its last value when no successful load occurs.
REQ-028 A store followed by a load to the same word on the next cycle SHALL return the stored data.
REQ-029 Back-to-back requests, one per cycle, SHALL be sustained with no bubbles in IDLE.

Reset
REQ-030 rst_n low SHALL immediately force state INIT, clearIdx 0, readdata 0, readValid 0, ready 0, misaligned 0, outOfRange 0.
REQ-031 Reset asserted mid-INIT or mid-operation SHALL restart a full DEPTH-cycle clear after release; no in-flight load completes.

Verification
REQ-032 Release reset (DEPTH=256) -> ready 0 for 256 cycles then 1; word load from 0x3FC -> readdata 0x00000000, readValid pulse.
REQ-033 Word store 100 at 0x0, word store 20 at 0x4, word load 0x0 then 0x4 -> readdata 100 then 20, readValid each following cycle.
REQ-034 After REQ-033, byte store 0x80 at 0x5; signed byte load at 0x5 -> 0xFFFFFF80; unsigned -> 0x00000080; word load 0x4 -> 0x00008014.
REQ-035 Half load at 0x3 -> misaligned pulse, no readValid, readdata unchanged; word store 0xDEADBEEF at 0x400 -> outOfRange pulse, word load 0x0 still 100.
REQ-036 memWrite=memRead=1 at 0x8 with writedata 7 -> no readValid; later word load 0x8 -> 7.
REQ-037 Assert rst_n low at cycle 100 of INIT and again during a load -> all outputs 0 immediately; ready returns only 256 cycles after each release.
